multiplicator_arbiter: RTL and testbench
========================================

// Module: multiplicator_arbiter
// PURPOSE
//  Shares one shift-and-add multiplier among N_REQ requesters. Round-robin arbitration selects a
//  requester, issues its packed operands to the multiplier, waits for completion, and returns the
//  product to that requester with a one-cycle done pulse. Sits between client blocks and the multiplier.
// PARAMETERS
//  DATA_WIDTH     8   operand width; product and packed operand bus are 2*DATA_WIDTH
//  N_REQ          4   number of requesters (2..8)
//  TIMEOUT_CYCLES 64  WAIT-state watchdog limit (used only with MULT_ARB_TIMEOUT_EN)
// PORTS
//  clk           in   1                   clock, rising edge
//  rst_n         in   1                   asynchronous reset, active low
//  req_i         in   N_REQ               per-requester request level
//  data_req_i    in   N_REQ*2*DATA_WIDTH  per-requester operands {a,b}; slot i at [i*2DW +: 2DW], a in upper half
//  gnt_o         out  N_REQ               one-hot pulse: operands of requester i captured this cycle
//  done_o        out  N_REQ               one-hot pulse: result_o valid for requester i
//  result_o      out  2*DATA_WIDTH        product, valid only while done_o != 0
//  err_o         out  1                   pulses with done_o on timeout (tied 0 without macro)
//  mul_req_o     out  1                   one-cycle start pulse to multiplier
//  mul_data_o    out  2*DATA_WIDTH        operands to multiplier, stable from mul_req_o until mul_done_i
//  mul_done_i    in   1                   one-cycle completion pulse from multiplier
//  mul_result_i  in   2*DATA_WIDTH        product, sampled when mul_done_i=1
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, timeout counter 0.
//  FSM IDLE->ISSUE->WAIT->RESP->IDLE.
//  IDLE: if any req_i, grant first set bit at or above pointer (wrap); gnt_o pulse, capture slot into
//   mul_data_o, pointer <= granted+1 mod N_REQ, go ISSUE. No request: stay, pointer unchanged.
//  ISSUE: mul_req_o=1 for exactly this cycle; go WAIT.
//  WAIT: on mul_done_i capture mul_result_i into result_o, go RESP.
//  RESP: done_o[granted]=1 one cycle, result_o valid; go IDLE. Next grant earliest the following cycle.
//  Latency: gnt_o -> mul_req_o 1 cycle; mul_done_i -> done_o 1 cycle.
//  Requester keeps req_i and its data stable until gnt_o; deasserting before grant withdraws it.
//  req_i of granted requester ignored until done_o; re-asserted request competes next IDLE.
//  mul_done_i outside WAIT ignored. Product width 2*DATA_WIDTH, no truncation.
//  Reset mid-operation: immediate return to reset values; in-flight product discarded.
// CONFIGURATION
//  MULT_ARB_TIMEOUT_EN defined: counter counts cycles in WAIT; at TIMEOUT_CYCLES without mul_done_i,
//   go RESP with result_o=0, err_o=1 with done_o; counter cleared on entering WAIT.
//  Undefined: WAIT indefinitely, no counter logic, err_o constant 0.
// STRUCTURE
//  mult_pkg: state encodings (IDLE/ISSUE/WAIT/RESP), default widths, clog2 constant for pointer.
//  Sub-module rr_arbiter: combinational round-robin pick (req, pointer -> one-hot, index);
//   FSM, capture registers and watchdog stay in multiplicator_arbiter.
// TESTING
//  Single req_i=0001, data {5,3}, model done after 9 cycles -> mul_data_o=0x0503, done_o=0001, result_o=15.
//  req_i=1111 held, pointer 0 -> grants 0,1,2,3,0 in order; each done_o matches its gnt_o index.
//  req_i=0101 with {7,10} and {255,255} -> results 70 and 0xFE01, grants alternate 0,2.
//  Spurious mul_done_i in IDLE and ISSUE -> no done_o, state unaffected.
//  rst_n low in WAIT -> all outputs 0 async; after release grant restarts from requester 0.
//  MULT_ARB_TIMEOUT_EN, multiplier silent -> after 64 WAIT cycles done_o with err_o=1, result_o=0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for multiplicator_arbiter: FSM state encoding, default sizes
// and the index-width helper used for the round-robin pointer.
package mult_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_e;

   localparam int unsigned DEF_DATA_WIDTH     = 8;
   localparam int unsigned DEF_N_REQ          = 4;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

   // Width of an index into n items; never below one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multiplicator_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping.
module rr_arbiter
   import mult_pkg::*;
#(
   parameter int unsigned N_REQ = DEF_N_REQ,
   parameter int unsigned PTR_W = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [PTR_W-1:0] idx_o,
   output logic             valid_o
);

   always_comb begin
      int unsigned j;
      j       = 0;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         j = (32'(ptr_i) + k) % N_REQ;
         if (!valid_o && req_i[PTR_W'(j)]) begin
            valid_o            = 1'b1;
            gnt_o[PTR_W'(j)]   = 1'b1;
            idx_o              = PTR_W'(j);
         end
      end
   end

endmodule

// File: rtl/multiplicator_arbiter.sv
// Shares one shift-and-add multiplier among N_REQ requesters with round-robin arbitration.
// Define MULT_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (err_o pulses with done_o on expiry).
module multiplicator_arbiter
   import mult_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int unsigned N_REQ          = DEF_N_REQ,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [N_REQ-1:0]                 req_i,
   input  logic [N_REQ*2*DATA_WIDTH-1:0]    data_req_i,
   output logic [N_REQ-1:0]                 gnt_o,
   output logic [N_REQ-1:0]                 done_o,
   output logic [2*DATA_WIDTH-1:0]          result_o,
   output logic                             err_o,
   output logic                             mul_req_o,
   output logic [2*DATA_WIDTH-1:0]          mul_data_o,
   input  logic                             mul_done_i,
   input  logic [2*DATA_WIDTH-1:0]          mul_result_i
);

   localparam int unsigned PW    = 2 * DATA_WIDTH;
   localparam int unsigned PTR_W = idx_width(N_REQ);

   state_e             state_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [N_REQ-1:0]   gnt_q;
   logic [N_REQ-1:0]   sel_q;
   logic [N_REQ-1:0]   done_q;
   logic [PW-1:0]      result_q;
   logic [PW-1:0]      mul_data_q;
   logic               mul_req_q;

   logic [N_REQ-1:0]   pick_gnt;
   logic [PTR_W-1:0]   pick_idx;
   logic               pick_valid;
   logic [PTR_W-1:0]   ptr_d;
   logic [PW-1:0]      slot_data;

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int unsigned TMO_W = idx_width(TIMEOUT_CYCLES);
   logic [TMO_W-1:0]   tmo_q;
   logic               err_q;
`endif

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .gnt_o   (pick_gnt),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   assign ptr_d = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

   // One-hot mux of the granted requester's operand slot.
   always_comb begin
      slot_data = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (pick_gnt[i]) slot_data = data_req_i[i*PW +: PW];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         gnt_q      <= '0;
         sel_q      <= '0;
         done_q     <= '0;
         result_q   <= '0;
         mul_data_q <= '0;
         mul_req_q  <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
         tmo_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         gnt_q     <= '0;
         done_q    <= '0;
         mul_req_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pick_valid) begin
                  gnt_q      <= pick_gnt;
                  sel_q      <= pick_gnt;
                  mul_data_q <= slot_data;
                  ptr_q      <= ptr_d;
                  state_q    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               mul_req_q <= 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
               tmo_q     <= '0;
`endif
               state_q   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (mul_done_i) begin
                  result_q <= mul_result_i;
                  done_q   <= sel_q;
                  state_q  <= ST_RESP;
               end
`ifdef MULT_ARB_TIMEOUT_EN
               else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
                  done_q   <= sel_q;
                  state_q  <= ST_RESP;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
`endif
            end
            ST_RESP: begin
               result_q <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
               err_q    <= 1'b0;
`endif
               state_q  <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign gnt_o      = gnt_q;
   assign done_o     = done_q;
   assign result_o   = result_q;
   assign mul_req_o  = mul_req_q;
   assign mul_data_o = mul_data_q;
`ifdef MULT_ARB_TIMEOUT_EN
   assign err_o      = err_q;
`else
   assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_multiplicator_arbiter.sv
// Self-checking bench for multiplicator_arbiter: scoreboard queues of expected grants and
// products, plus a behavioural multiplier with programmable latency.
`timescale 1ns/1ps
module tb_multiplicator_arbiter;

   localparam int unsigned DW = 8;
   localparam int unsigned N  = 4;
   localparam int unsigned PW = 2 * DW;

   typedef struct {
      int unsigned   idx;
      logic [PW-1:0] prod;
   } exp_t;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_i;
   logic [N*PW-1:0] data_req_i;
   logic [N-1:0]    gnt_o;
   logic [N-1:0]    done_o;
   logic [PW-1:0]   result_o;
   logic            err_o;
   logic            mul_req_o;
   logic [PW-1:0]   mul_data_o;
   logic            mul_done_i;
   logic [PW-1:0]   mul_result_i;

   logic            mdl_done, spur_done;
   logic [PW-1:0]   mdl_res, spur_res;
   logic            mul_en;
   int unsigned     mul_delay;

   int              tests, fails;
   logic [PW-1:0]   slot_v [N];
   exp_t            sb_q [$];
   int unsigned     gq [$];

   assign mul_done_i   = mdl_done | spur_done;
   assign mul_result_i = spur_done ? spur_res : mdl_res;

   multiplicator_arbiter #(
      .DATA_WIDTH     (DW),
      .N_REQ          (N),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req_i),
      .data_req_i   (data_req_i),
      .gnt_o        (gnt_o),
      .done_o       (done_o),
      .result_o     (result_o),
      .err_o        (err_o),
      .mul_req_o    (mul_req_o),
      .mul_data_o   (mul_data_o),
      .mul_done_i   (mul_done_i),
      .mul_result_i (mul_result_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural multiplier: latches operands on mul_req_o, answers mul_delay cycles later.
   initial begin
      logic [PW-1:0] op;
      mdl_done = 1'b0;
      mdl_res  = '0;
      forever begin
         @(negedge clk);
         if (mul_en && mul_req_o && rst_n) begin
            op = mul_data_o;
            repeat (mul_delay) @(negedge clk);
            mdl_res  = PW'(op[PW-1:DW]) * PW'(op[DW-1:0]);
            mdl_done = 1'b1;
            @(negedge clk);
            mdl_done = 1'b0;
            mdl_res  = '0;
         end
      end
   end

   function automatic logic [PW-1:0] prod_of(input logic [PW-1:0] ab);
      return PW'(ab[PW-1:DW]) * PW'(ab[DW-1:0]);
   endfunction

   task automatic set_slot(input int unsigned i, input logic [DW-1:0] a, input logic [DW-1:0] b);
      slot_v[i] = {a, b};
      data_req_i[i*PW +: PW] = {a, b};
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_i = '0;
      sb_q.delete();
      gq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #1;
      tests++;
      if ({gnt_o, done_o, result_o, err_o, mul_req_o, mul_data_o} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got gnt=%b done=%b res=%h err=%b mreq=%b mdata=%h, expected all 0",
                  gnt_o, done_o, result_o, err_o, mul_req_o, mul_data_o);
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      tests++;
      if (gnt_o !== '0 || mul_req_o !== 1'b0) begin
         fails++;
         $display("FAIL idle_no_req: got gnt=%b mreq=%b, expected 0000/0", gnt_o, mul_req_o);
      end
   endtask

   task automatic test_single();
      exp_t x;
      bit   seen_done, prev_gnt, prev_mdone;
      do_reset();
      mul_en    = 1'b1;
      mul_delay = 9;
      set_slot(0, 8'd5, 8'd3);
      sb_q.push_back('{0, 16'd15});
      req_i = 4'b0001;
      seen_done  = 0;
      prev_gnt   = 0;
      prev_mdone = 0;
      for (int c = 0; c < 200 && !seen_done; c++) begin
         @(negedge clk);
         #1;
         if (prev_gnt) begin
            tests++;
            if (mul_req_o !== 1'b1) begin
               fails++;
               $display("FAIL single_issue_latency: got mul_req_o=%b, expected 1", mul_req_o);
            end
         end
         if (prev_mdone) begin
            tests++;
            if (done_o !== 4'b0001) begin
               fails++;
               $display("FAIL single_done_latency: got done_o=%b, expected 0001", done_o);
            end
         end
         if (gnt_o != '0) begin
            tests++;
            if (gnt_o !== 4'b0001 || mul_data_o !== 16'h0503) begin
               fails++;
               $display("FAIL single_grant: got gnt=%b mdata=%h, expected 0001/0503", gnt_o, mul_data_o);
            end
            req_i = '0;
         end
         if (done_o != '0) begin
            seen_done = 1;
            x = sb_q.pop_front();
            tests++;
            if (done_o !== N'(1 << x.idx) || result_o !== x.prod || err_o !== 1'b0) begin
               fails++;
               $display("FAIL single_done: got done=%b res=%0d err=%b, expected %b/%0d/0",
                        done_o, result_o, err_o, N'(1 << x.idx), x.prod);
            end
         end
         prev_gnt   = (gnt_o != '0);
         prev_mdone = mul_done_i;
      end
      tests++;
      if (!seen_done) begin
         fails++;
         $display("FAIL single_timeout: got no done_o, expected done_o=0001");
      end
   endtask

   task automatic test_round_robin();
      exp_t        x;
      int unsigned e, ng;
      do_reset();
      mul_en    = 1'b1;
      mul_delay = 3;
      for (int unsigned i = 0; i < N; i++)
         set_slot(i, DW'($urandom_range(1, 255)), DW'($urandom_range(1, 255)));
      for (int unsigned k = 0; k < 5; k++) begin
         gq.push_back(k % N);
         sb_q.push_back('{k % N, prod_of(slot_v[k % N])});
      end
      req_i = '1;
      ng    = 0;
      for (int c = 0; c < 1000 && sb_q.size() != 0; c++) begin
         @(negedge clk);
         #1;
         if (gnt_o != '0) begin
            if (gq.size() != 0) e = gq.pop_front();
            else e = N;
            tests++;
            if (gnt_o !== N'(1 << e) || mul_data_o !== slot_v[e]) begin
               fails++;
               $display("FAIL rr_grant%0d: got gnt=%b mdata=%h, expected index %0d", ng, gnt_o, mul_data_o, e);
            end
            ng++;
            if (ng == 5) req_i = '0;
         end
         if (done_o != '0) begin
            tests++;
            if (sb_q.size() == 0) begin
               fails++;
               $display("FAIL rr_extra_done: got done=%b, expected none", done_o);
            end else begin
               x = sb_q.pop_front();
               if (done_o !== N'(1 << x.idx) || result_o !== x.prod || err_o !== 1'b0) begin
                  fails++;
                  $display("FAIL rr_done: got done=%b res=%h err=%b, expected %b/%h/0",
                           done_o, result_o, err_o, N'(1 << x.idx), x.prod);
               end
            end
         end
      end
      tests++;
      if (sb_q.size() != 0 || gq.size() != 0) begin
         fails++;
         $display("FAIL rr_timeout: got %0d results outstanding, expected 0", sb_q.size());
      end
   endtask

   task automatic test_two_req();
      exp_t        x;
      int unsigned e, ng;
      do_reset();
      mul_en    = 1'b1;
      mul_delay = 5;
      set_slot(0, 8'd7, 8'd10);
      set_slot(1, 8'd11, 8'd13);
      set_slot(2, 8'd255, 8'd255);
      set_slot(3, 8'd2, 8'd99);
      for (int k = 0; k < 2; k++) begin
         gq.push_back(0);
         sb_q.push_back('{0, 16'd70});
         gq.push_back(2);
         sb_q.push_back('{2, 16'hFE01});
      end
      req_i = 4'b0101;
      ng    = 0;
      for (int c = 0; c < 1000 && sb_q.size() != 0; c++) begin
         @(negedge clk);
         #1;
         if (gnt_o != '0) begin
            if (gq.size() != 0) e = gq.pop_front();
            else e = N;
            tests++;
            if (gnt_o !== N'(1 << e) || mul_data_o !== slot_v[e]) begin
               fails++;
               $display("FAIL two_grant%0d: got gnt=%b mdata=%h, expected index %0d", ng, gnt_o, mul_data_o, e);
            end
            ng++;
            if (ng == 4) req_i = '0;
         end
         if (done_o != '0) begin
            tests++;
            if (sb_q.size() == 0) begin
               fails++;
               $display("FAIL two_extra_done: got done=%b, expected none", done_o);
            end else begin
               x = sb_q.pop_front();
               if (done_o !== N'(1 << x.idx) || result_o !== x.prod) begin
                  fails++;
                  $display("FAIL two_done: got done=%b res=%h, expected %b/%h",
                           done_o, result_o, N'(1 << x.idx), x.prod);
               end
            end
         end
      end
      tests++;
      if (sb_q.size() != 0) begin
         fails++;
         $display("FAIL two_timeout: got %0d results outstanding, expected 0", sb_q.size());
      end
   endtask

   task automatic test_spurious();
      exp_t x;
      bit   found;
      do_reset();
      mul_en    = 1'b1;
      mul_delay = 4;
      spur_res  = 16'h1234;
      spur_done = 1'b1;
      @(negedge clk);
      #1;
      spur_done = 1'b0;
      tests++;
      if (done_o !== '0 || gnt_o !== '0 || mul_req_o !== 1'b0 || result_o !== '0) begin
         fails++;
         $display("FAIL spur_idle: got done=%b gnt=%b mreq=%b res=%h, expected all 0",
                  done_o, gnt_o, mul_req_o, result_o);
      end
      set_slot(1, 8'd9, 8'd12);
      sb_q.push_back('{1, 16'd108});
      req_i = 4'b0010;
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         #1;
         if (gnt_o != '0) found = 1;
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL spur_grant: got no gnt_o, expected 0010");
      end
      req_i     = '0;
      spur_res  = 16'hBEEF;
      spur_done = 1'b1;
      @(negedge clk);
      #1;
      spur_done = 1'b0;
      tests++;
      if (done_o !== '0 || mul_req_o !== 1'b1 || result_o !== '0) begin
         fails++;
         $display("FAIL spur_issue: got done=%b mreq=%b res=%h, expected 0000/1/0000", done_o, mul_req_o, result_o);
      end
      found = 0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(negedge clk);
         #1;
         if (done_o != '0) begin
            found = 1;
            x = sb_q.pop_front();
            tests++;
            if (done_o !== N'(1 << x.idx) || result_o !== x.prod) begin
               fails++;
               $display("FAIL spur_result: got done=%b res=%0d, expected %b/%0d",
                        done_o, result_o, N'(1 << x.idx), x.prod);
            end
         end
      end
      tests++;
      if (!found) begin
         fails++;
         $display("FAIL spur_timeout: got no done_o, expected 0010");
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      do_reset();
      mul_en = 1'b0;
      set_slot(3, 8'd200, 8'd100);
      req_i = 4'b1000;
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         #1;
         if (gnt_o != '0) found = 1;
      end
      req_i = '0;
      repeat (5) @(negedge clk);
      #1;
      tests++;
      if (!found || mul_data_o !== slot_v[3]) begin
         fails++;
         $display("FAIL rstmid_pre: got grant=%0d mdata=%h, expected 1/%h", found, mul_data_o, slot_v[3]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({gnt_o, done_o, result_o, err_o, mul_req_o, mul_data_o} !== '0) begin
         fails++;
         $display("FAIL rstmid_async: got gnt=%b done=%b res=%h err=%b mreq=%b mdata=%h, expected all 0",
                  gnt_o, done_o, result_o, err_o, mul_req_o, mul_data_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mul_en    = 1'b1;
      mul_delay = 2;
      set_slot(0, 8'd13, 8'd17);
      req_i = '1;
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         #1;
         if (gnt_o != '0) found = 1;
      end
      req_i = '0;
      tests++;
      if (gnt_o !== 4'b0001 || mul_data_o !== 16'h0D11) begin
         fails++;
         $display("FAIL rstmid_regrant: got gnt=%b mdata=%h, expected 0001/0d11", gnt_o, mul_data_o);
      end
      found = 0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(negedge clk);
         #1;
         if (done_o != '0) found = 1;
      end
      tests++;
      if (!found || done_o !== 4'b0001 || result_o !== 16'd221) begin
         fails++;
         $display("FAIL rstmid_result: got done=%b res=%0d, expected 0001/221", done_o, result_o);
      end
   endtask

`ifdef MULT_ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit found;
      int cnt;
      do_reset();
      mul_en = 1'b0;
      set_slot(2, 8'd17, 8'd19);
      req_i = 4'b0100;
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         #1;
         if (mul_req_o) found = 1;
         if (gnt_o != '0) req_i = '0;
      end
      cnt = 0;
      found = 0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge clk);
         #1;
         cnt++;
         if (done_o != '0) found = 1;
      end
      tests++;
      if (!found || cnt != 64 || done_o !== 4'b0100 || err_o !== 1'b1 || result_o !== '0) begin
         fails++;
         $display("FAIL timeout: got cycles=%0d done=%b err=%b res=%h, expected 64/0100/1/0000",
                  cnt, done_o, err_o, result_o);
      end
      @(negedge clk);
      #1;
      tests++;
      if (err_o !== 1'b0 || done_o !== '0) begin
         fails++;
         $display("FAIL timeout_pulse: got err=%b done=%b, expected 0/0000", err_o, done_o);
      end
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL global_watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      tests      = 0;
      fails      = 0;
      rst_n      = 1'b0;
      req_i      = '0;
      data_req_i = '0;
      spur_done  = 1'b0;
      spur_res   = '0;
      mul_en     = 1'b0;
      mul_delay  = 1;
      for (int unsigned i = 0; i < N; i++) slot_v[i] = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_two_req();
      test_spurious();
      test_reset_mid();
`ifdef MULT_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
